// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Owns the shared SPI pins (SCK/MOSI) and serialises round-robin
//            access by the preamp gain loader and the DAC writer. SCK is
//            derived from clock_in by a programmable divider. Exactly one
//            chip select is driven low at a time, and the other on-board SPI
//            parts are held deselected.
// Options  : `define SPI_READBACK_EN adds SPI_MISO capture with per-client
//            read-back registers (amp_rdata / dac_rdata).
// Revision : 1.0  initial release
// ============================================================================
module spi_bus_arbiter #(
    parameter int CLK_DIV  = 2,   // clock_in cycles per SCK half-period (>=1)
    parameter int AMP_BITS = 8,   // amp frame length
    parameter int DAC_BITS = 32,  // DAC frame length (>= AMP_BITS)
    parameter int GAP_CYC  = 4    // minimum all-CS-high cycles between frames
) (
    input  logic                clock_in,
    input  logic                rst_n,
    input  logic                amp_req,
    input  logic [AMP_BITS-1:0] amp_data,
    output logic                amp_done,
    input  logic                dac_req,
    input  logic [DAC_BITS-1:0] dac_data,
    output logic                dac_done,
    output logic                busy,
`ifdef SPI_READBACK_EN
    input  logic                SPI_MISO,
    output logic [AMP_BITS-1:0] amp_rdata,
    output logic [DAC_BITS-1:0] dac_rdata,
`endif
    output logic                SPI_SCK,
    output logic                SPI_MOSI,
    output logic                AMP_CS,
    output logic                DAC_CS,
    output logic                AMP_SHDN,
    output logic                DAC_CLR,
    output logic                SPI_SS_B,
    output logic                SF_CE0,
    output logic                FPGA_INIT_B,
    output logic                AD_CONV
);

    localparam int BW = $clog2(DAC_BITS) + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DW-1:0] c_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] c_GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [BW-1:0] c_AMP_LAST = BW'(AMP_BITS - 1);
    localparam logic [BW-1:0] c_DAC_LAST = BW'(DAC_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_SCK_HI = 3'd2,
        S_SCK_LO = 3'd3,
        S_HOLD   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_div;
    logic [GW-1:0]       r_gap;
    logic [BW-1:0]       r_bit_cnt;
    logic [DAC_BITS-1:0] r_shift;
    logic                r_sel_dac;     // client owning the current frame
    logic                r_last_dac;    // round-robin pointer: last client granted
    logic                r_hold_tail;   // second half of the HOLD period
    logic                r_amp_pend;
    logic                r_dac_pend;
    logic                r_sck;
    logic                r_amp_cs;
    logic                r_dac_cs;
    logic                r_amp_done;
    logic                r_dac_done;

    logic                w_div_end;
    logic                w_amp_want;
    logic                w_dac_want;
    logic                w_pick_dac;
    logic                w_grant;
    logic [BW-1:0]       w_last_bit;
    logic                w_hi_entry;
    logic                w_frame_end;
    logic [DAC_BITS-1:0] w_amp_aligned;

    // A request counts in the same cycle it arrives, so an idle bus answers
    // one cycle after the request edge.
    assign w_amp_want  = r_amp_pend | amp_req;
    assign w_dac_want  = r_dac_pend | dac_req;
    // On a tie the client not served last wins.
    assign w_pick_dac  = w_dac_want & (~w_amp_want | ~r_last_dac);
    // Grants happen in IDLE or in the final GAP cycle, so a queued frame
    // follows the previous one after exactly GAP_CYC cycles with CS high.
    assign w_grant     = (w_amp_want | w_dac_want) &
                         ((r_state == S_IDLE) | ((r_state == S_GAP) & (r_gap == c_GAP_LAST)));
    assign w_div_end   = (r_div == c_DIV_LAST);
    assign w_last_bit  = r_sel_dac ? c_DAC_LAST : c_AMP_LAST;
    assign w_hi_entry  = w_div_end & ((r_state == S_SETUP) | (r_state == S_SCK_LO));
    assign w_frame_end = w_div_end & (r_state == S_HOLD) & r_hold_tail;
    // Amp words share the shift register, left-aligned so MOSI is always the MSB.
    assign w_amp_aligned = DAC_BITS'(amp_data) << (DAC_BITS - AMP_BITS);

    // Half-period divider: runs in every timed state and wraps at CLK_DIV-1.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if ((r_state inside {S_IDLE, S_GAP}) || w_div_end) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Pending flags: set by any request cycle, cleared only in the grant cycle.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_amp_pend <= 1'b0;
            r_dac_pend <= 1'b0;
        end else begin
            if (w_grant && !w_pick_dac) begin
                r_amp_pend <= 1'b0;
            end else if (amp_req) begin
                r_amp_pend <= 1'b1;
            end
            if (w_grant && w_pick_dac) begin
                r_dac_pend <= 1'b0;
            end else if (dac_req) begin
                r_dac_pend <= 1'b1;
            end
        end
    end

    // Frame sequencer; all bus pins come straight from these registers.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_sel_dac   <= 1'b0;
            r_last_dac  <= 1'b1;
            r_hold_tail <= 1'b0;
            r_sck       <= 1'b0;
            r_amp_cs    <= 1'b1;
            r_dac_cs    <= 1'b1;
            r_amp_done  <= 1'b0;
            r_dac_done  <= 1'b0;
        end else begin
            r_amp_done <= 1'b0;
            r_dac_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_gap <= '0;
                end
                S_SETUP, S_SCK_LO: begin
                    if (w_div_end) begin
                        r_state <= S_SCK_HI;
                        r_sck   <= 1'b1;
                    end
                end
                S_SCK_HI: begin
                    if (w_div_end) begin
                        r_sck <= 1'b0;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state     <= S_HOLD;
                            r_hold_tail <= 1'b0;
                        end else begin
                            r_state   <= S_SCK_LO;
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                            r_shift   <= {r_shift[DAC_BITS-2:0], 1'b0};
                        end
                    end
                end
                // HOLD spans a full SCK period after the last rising edge,
                // giving a CS-low window of (2N+2) half-periods.
                S_HOLD: begin
                    if (w_div_end) begin
                        if (!r_hold_tail) begin
                            r_hold_tail <= 1'b1;
                        end else begin
                            r_state    <= S_GAP;
                            r_gap      <= '0;
                            r_amp_cs   <= 1'b1;
                            r_dac_cs   <= 1'b1;
                            r_shift    <= '0;
                            r_amp_done <= ~r_sel_dac;
                            r_dac_done <= r_sel_dac;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // A grant overrides the IDLE/GAP bookkeeping above.
            if (w_grant) begin
                r_state    <= S_SETUP;
                r_sel_dac  <= w_pick_dac;
                r_last_dac <= w_pick_dac;
                r_bit_cnt  <= '0;
                r_sck      <= 1'b0;
                r_amp_cs   <= w_pick_dac;
                r_dac_cs   <= ~w_pick_dac;
                r_shift    <= w_pick_dac ? dac_data : w_amp_aligned;
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [DAC_BITS-1:0] r_rx;
    logic [AMP_BITS-1:0] r_amp_rdata;
    logic [DAC_BITS-1:0] r_dac_rdata;

    // MISO capture on each SCK rising edge; results published at frame end.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rx        <= '0;
            r_amp_rdata <= '0;
            r_dac_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_rx <= '0;
            end else if (w_hi_entry) begin
                r_rx <= {r_rx[DAC_BITS-2:0], SPI_MISO};
            end
            if (w_frame_end) begin
                if (r_sel_dac) begin
                    r_dac_rdata <= r_rx;
                end else begin
                    r_amp_rdata <= r_rx[AMP_BITS-1:0];
                end
            end
        end
    end

    assign amp_rdata = r_amp_rdata;
    assign dac_rdata = r_dac_rdata;
`endif

    assign busy        = (r_state != S_IDLE);
    assign amp_done    = r_amp_done;
    assign dac_done    = r_dac_done;
    assign SPI_SCK     = r_sck;
    assign SPI_MOSI    = r_shift[DAC_BITS-1];
    assign AMP_CS      = r_amp_cs;
    assign DAC_CS      = r_dac_cs;
    assign AMP_SHDN    = 1'b0;
    assign DAC_CLR     = 1'b1;
    assign SPI_SS_B    = 1'b1;
    assign SF_CE0      = 1'b1;
    assign FPGA_INIT_B = 1'b1;
    assign AD_CONV     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Purpose  : Self-checking bench for spi_bus_arbiter. A pin-level monitor
//            rebuilds each frame from CS/SCK/MOSI and compares it with a
//            transaction-level model of request queuing and round-robin.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int CLK_DIV  = 2;
    localparam int AMP_BITS = 8;
    localparam int DAC_BITS = 32;
    localparam int GAP_CYC  = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                amp_req, dac_req;
    logic [AMP_BITS-1:0] amp_data;
    logic [DAC_BITS-1:0] dac_data;
    logic                amp_done, dac_done, busy;
    logic                SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS;
    logic                AMP_SHDN, DAC_CLR, SPI_SS_B, SF_CE0, FPGA_INIT_B, AD_CONV;
`ifdef SPI_READBACK_EN
    logic                SPI_MISO;
    logic [AMP_BITS-1:0] amp_rdata;
    logic [DAC_BITS-1:0] dac_rdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spi_bus_arbiter #(
        .CLK_DIV (CLK_DIV),
        .AMP_BITS(AMP_BITS),
        .DAC_BITS(DAC_BITS),
        .GAP_CYC (GAP_CYC)
    ) u_dut (
        .clock_in   (clk),
        .rst_n      (rst_n),
        .amp_req    (amp_req),
        .amp_data   (amp_data),
        .amp_done   (amp_done),
        .dac_req    (dac_req),
        .dac_data   (dac_data),
        .dac_done   (dac_done),
        .busy       (busy),
`ifdef SPI_READBACK_EN
        .SPI_MISO   (SPI_MISO),
        .amp_rdata  (amp_rdata),
        .dac_rdata  (dac_rdata),
`endif
        .SPI_SCK    (SPI_SCK),
        .SPI_MOSI   (SPI_MOSI),
        .AMP_CS     (AMP_CS),
        .DAC_CS     (DAC_CS),
        .AMP_SHDN   (AMP_SHDN),
        .DAC_CLR    (DAC_CLR),
        .SPI_SS_B   (SPI_SS_B),
        .SF_CE0     (SF_CE0),
        .FPGA_INIT_B(FPGA_INIT_B),
        .AD_CONV    (AD_CONV)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic                e_rst, e_amp_req, e_dac_req, e_miso;
    logic [AMP_BITS-1:0] e_amp_data;
    logic [DAC_BITS-1:0] e_dac_data;

    logic        m_pend_amp, m_pend_dac, m_last_dac, m_in_frame, m_cur_dac;
    logic        p_sck, p_mosi;
    logic        mo_cs_low, mo_want_a, mo_want_d, mo_pick_d, mo_end;
    int          m_hi_run, m_low_cnt, m_nbits, m_amp_frames, m_dac_frames;
    int          m_order, m_last_gap, mo_n;
    logic [31:0] m_bits, m_exp_word, m_rx;

    initial begin
        m_amp_frames = 0;
        m_dac_frames = 0;
        m_order      = 0;
        m_in_frame   = 1'b0;
        m_pend_amp   = 1'b0;
        m_pend_dac   = 1'b0;
        m_hi_run     = GAP_CYC + 1;
    end

    // Inputs as the DUT sees them at the active edge.
    always @(posedge clk) begin
        e_rst      = rst_n;
        e_amp_req  = amp_req;
        e_dac_req  = dac_req;
        e_amp_data = amp_data;
        e_dac_data = dac_data;
`ifdef SPI_READBACK_EN
        e_miso     = SPI_MISO;
`else
        e_miso     = 1'b0;
`endif
    end

    // Pin monitor and scoreboard, sampled half a cycle after each edge.
    always @(negedge clk) begin
        if (!rst_n || !e_rst) begin
            m_pend_amp = 1'b0;
            m_pend_dac = 1'b0;
            m_last_dac = 1'b1;
            m_in_frame = 1'b0;
            m_hi_run   = GAP_CYC + 1;
            m_order    = 0;
            p_sck      = 1'b0;
            p_mosi     = 1'b0;
        end else begin
            mo_cs_low = !AMP_CS || !DAC_CS;
            mo_end    = m_in_frame && !mo_cs_low;
            check_val("cs_excl", {31'd0, !AMP_CS && !DAC_CS}, 32'd0);
            if (!m_in_frame) begin
                mo_want_a = m_pend_amp | e_amp_req;
                mo_want_d = m_pend_dac | e_dac_req;
                mo_pick_d = mo_want_d && (!mo_want_a || !m_last_dac);
                check_val("grant", {31'd0, mo_cs_low},
                          {31'd0, (mo_want_a || mo_want_d) && (m_hi_run >= GAP_CYC)});
                if (mo_cs_low) begin
                    check_val("grant_cs", {30'd0, AMP_CS, DAC_CS}, mo_pick_d ? 32'd2 : 32'd1);
                    m_in_frame = 1'b1;
                    m_cur_dac  = !DAC_CS;
                    m_last_dac = m_cur_dac;
                    m_last_gap = m_hi_run;
                    m_exp_word = m_cur_dac ? e_dac_data : {24'd0, e_amp_data};
                    m_low_cnt  = 0;
                    m_nbits    = 0;
                    m_bits     = 32'd0;
                    m_rx       = 32'd0;
                    m_order    = (m_order << 1) | int'(m_cur_dac);
                    if (m_cur_dac) begin
                        m_pend_dac = 1'b0;
                        m_pend_amp = m_pend_amp | e_amp_req;
                    end else begin
                        m_pend_amp = 1'b0;
                        m_pend_dac = m_pend_dac | e_dac_req;
                    end
                end else begin
                    m_pend_amp = m_pend_amp | e_amp_req;
                    m_pend_dac = m_pend_dac | e_dac_req;
                end
            end else begin
                m_pend_amp = m_pend_amp | e_amp_req;
                m_pend_dac = m_pend_dac | e_dac_req;
            end

            if (mo_cs_low) begin
                m_low_cnt++;
                if (SPI_SCK && !p_sck) begin
                    m_bits = {m_bits[30:0], SPI_MOSI};
                    m_rx   = {m_rx[30:0], e_miso};
                    m_nbits++;
                end
                if (SPI_SCK) check_val("mosi_hold", {31'd0, SPI_MOSI}, {31'd0, p_mosi});
            end else begin
                check_val("sck_idle", {31'd0, SPI_SCK}, 32'd0);
                check_val("mosi_idle", {31'd0, SPI_MOSI}, 32'd0);
            end

            if (mo_end) begin
                mo_n = m_cur_dac ? DAC_BITS : AMP_BITS;
                check_val("cs_len", m_low_cnt, (2 * mo_n + 2) * CLK_DIV);
                check_val("nbits", m_nbits, mo_n);
                check_val("word", m_bits, m_exp_word);
`ifdef SPI_READBACK_EN
                if (m_cur_dac) check_val("dac_rdata", dac_rdata, m_rx);
                else           check_val("amp_rdata", {24'd0, amp_rdata}, m_rx);
`endif
                m_in_frame = 1'b0;
                m_hi_run   = 1;
                if (m_cur_dac) m_dac_frames++;
                else           m_amp_frames++;
            end else if (!mo_cs_low && m_hi_run <= GAP_CYC) begin
                m_hi_run++;
            end

            check_val("done", {30'd0, amp_done, dac_done},
                      mo_end ? (m_cur_dac ? 32'd1 : 32'd2) : 32'd0);
            check_val("busy", {31'd0, busy}, {31'd0, mo_cs_low || (m_hi_run <= GAP_CYC)});
            p_sck  = SPI_SCK;
            p_mosi = SPI_MOSI;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
`ifdef SPI_READBACK_EN
            SPI_MISO = 1'($urandom_range(0, 1));
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 4000; k++) begin
            if (!busy && !m_pend_amp && !m_pend_dac && !m_in_frame) break;
            tick(1);
        end
        check_val("idle", {29'd0, busy, m_pend_amp, m_pend_dac}, 32'd0);
    endtask

    int a0, d0;
    logic [31:0] w_tmp;

    initial begin
        rst_n    = 1'b0;
        amp_req  = 1'b0;
        dac_req  = 1'b0;
        amp_data = '0;
        dac_data = '0;
`ifdef SPI_READBACK_EN
        SPI_MISO = 1'b0;
`endif
        tick(3);
        check_val("rst_pins", {25'd0, AMP_CS, DAC_CS, SPI_SCK, SPI_MOSI, busy, amp_done, dac_done},
                  32'h60);
        check_val("const_pins", {26'd0, AMP_SHDN, DAC_CLR, SPI_SS_B, SF_CE0, FPGA_INIT_B, AD_CONV},
                  32'h1E);
        rst_n = 1'b1;
        tick(2);

        // Single amp frame
        a0 = m_amp_frames; d0 = m_dac_frames;
        amp_data = 8'h11; amp_req = 1'b1;
        tick(1);
        amp_req = 1'b0; amp_data = 8'hFF;
        wait_idle();
        check_val("t1_frames", m_amp_frames - a0, 1);
        check_val("t1_dac", m_dac_frames - d0, 0);
        check_val("t1_word", m_bits, 32'h11);
        check_val("t1_len", m_low_cnt, 18 * CLK_DIV);

        // Single DAC frame
        d0 = m_dac_frames;
        dac_data = 32'h0030_0FFF; dac_req = 1'b1;
        tick(1);
        dac_req = 1'b0; dac_data = 32'hDEAD_BEEF;
        wait_idle();
        check_val("t2_frames", m_dac_frames - d0, 1);
        check_val("t2_word", m_bits, 32'h0030_0FFF);
        check_val("t2_len", m_low_cnt, 66 * CLK_DIV);

        // Simultaneous pairs after reset: amp, then DAC, then amp
        do_reset();
        amp_data = 8'($urandom); dac_data = $urandom;
        amp_req = 1'b1; dac_req = 1'b1;
        tick(1);
        amp_req = 1'b0; dac_req = 1'b0;
        tick(3);
        amp_req = 1'b1; dac_req = 1'b1;
        tick(1);
        amp_req = 1'b0; dac_req = 1'b0;
        wait_idle();
        check_val("t3_order", m_order, 32'd2);
        check_val("t3_gap", m_last_gap, GAP_CYC);

        // amp_req held through its own frame, data changed mid-frame
        a0 = m_amp_frames;
        amp_data = 8'h3C; amp_req = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            amp_data = 8'($urandom);
            tick(1);
        end
        amp_req = 1'b0; amp_data = 8'hC3;
        wait_idle();
        check_val("t4_frames", m_amp_frames - a0, 2);
        check_val("t4_word2", m_bits, 32'hC3);

        // Reset in the middle of a DAC frame
        d0 = m_dac_frames;
        dac_data = $urandom; dac_req = 1'b1;
        tick(1);
        dac_req = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (m_in_frame && m_cur_dac && m_nbits >= 10) break;
            tick(1);
        end
        check_val("t5_reached", m_nbits, 10);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst", {27'd0, DAC_CS, AMP_CS, SPI_SCK, busy, dac_done}, 32'h18);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_val("t5_aborted", m_dac_frames - d0, 0);
        w_tmp = $urandom | 32'h8000_0001;
        dac_data = w_tmp; dac_req = 1'b1;
        tick(1);
        dac_req = 1'b0;
        wait_idle();
        check_val("t5_frames", m_dac_frames - d0, 1);
        check_val("t5_word", m_bits, w_tmp);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            amp_req  = ($urandom_range(0, 7) == 0);
            dac_req  = ($urandom_range(0, 9) == 0);
            amp_data = 8'($urandom);
            dac_data = $urandom;
            tick(1);
        end
        amp_req = 1'b0; dac_req = 1'b0;
        wait_idle();
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
